// File: rtl/qlf_k4n8_cfg_slice_if.sv
// Slice pin bundle: serial config chain, status, and the LUT/carry datapath pins.
// Latency: none; wires only.
// Backpressure: none; the config chain shifts one bit per enabled cycle unconditionally.
interface qlf_k4n8_cfg_slice_if #(
  parameter int NUM_BLE = 8
);
  logic                   cfg_en;
  logic                   cfg_din;
  logic                   cfg_dout;
  logic                   cfg_done;
  logic                   cfg_err;
  logic                   ce;
  logic [4*NUM_BLE-1:0]   in;
  logic                   cin;
  logic [NUM_BLE-1:0]     out;
  logic                   cout;

  // Stimulus / upstream side.
  modport master (
    output cfg_en, cfg_din, ce, in, cin,
    input  cfg_dout, cfg_done, cfg_err, out, cout
  );

  // Slice side.
  modport slave (
    input  cfg_en, cfg_din, ce, in, cin,
    output cfg_dout, cfg_done, cfg_err, out, cout
  );
endinterface

// File: rtl/qlf_k4n8_cfg_slice.sv
// k4n8 logic slice: NUM_BLE LUT4/adder BLEs programmed via a serial config chain.
// Latency: LUT/carry combinational; registered outputs one cycle after capture; done one cycle after load ends.
// Backpressure: none; one config bit shifts per cfg_en cycle. Optional macro QLF_SLICE_CARRY_EN enables the carry chain.
module qlf_k4n8_cfg_slice #(
  parameter int NUM_BLE = 8
) (
  input  logic                   C,
  input  logic                   RN,
  qlf_k4n8_cfg_slice_if.slave    bus
);
  localparam int CFG_BITS = 18;
  localparam int CFG_W    = NUM_BLE * CFG_BITS;
  localparam int CNT_W    = $clog2(CFG_W + 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_W);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CFG_W + 1);

  typedef enum logic [1:0] {UNCFG, LOAD, RUN} state_e;

  state_e             state_q, state_d;
  logic [CFG_W-1:0]   cfg_q, cfg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic [NUM_BLE-1:0] ff_q, ff_d;

  logic [NUM_BLE-1:0] lut;
  logic [NUM_BLE-1:0] byp;
  logic               cout_raw;
  logic [15:0]        tbl;
  logic [3:0]         li;
`ifdef QLF_SLICE_CARRY_EN
  logic               carry;
`else
  // cin has no function without the carry chain.
  logic               unused_cin;
  assign unused_cin = bus.cin;
`endif

  // LUT evaluation and ripple carry, walked from BLE0 upward.
  always_comb begin
    lut      = '0;
    byp      = '0;
    cout_raw = 1'b0;
    tbl      = '0;
    li       = '0;
`ifdef QLF_SLICE_CARRY_EN
    carry    = bus.cin;
`endif
    for (int i = 0; i < NUM_BLE; i++) begin
      tbl    = cfg_q[CFG_BITS*i +: 16];
      byp[i] = cfg_q[CFG_BITS*i + 17];
      li     = bus.in[4*i +: 4];
`ifdef QLF_SLICE_CARRY_EN
      if (cfg_q[CFG_BITS*i + 16]) li[2] = carry;
`endif
      lut[i] = tbl[li];
`ifdef QLF_SLICE_CARRY_EN
      // Upper LUT quarters double as propagate (8..11) and generate (12..15).
      carry  = tbl[{2'b10, li[1:0]}] ? carry : tbl[{2'b11, li[1:0]}];
`endif
    end
`ifdef QLF_SLICE_CARRY_EN
    cout_raw = carry;
`endif
  end

  // Load/run sequencing, config shift, bit count and output flop capture.
  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ff_d    = ff_q;
    case (state_q)
      LOAD: begin
        if (bus.cfg_en) begin
          cfg_d = {cfg_q[CFG_W-2:0], bus.cfg_din};
          cnt_d = (cnt_q == CNT_SAT) ? CNT_SAT : cnt_q + CNT_ONE;
        end else if (cnt_q == CNT_FULL) begin
          state_d = RUN;
        end else begin
          state_d = UNCFG;
          err_d   = 1'b1;
        end
      end
      default: begin
        // UNCFG and RUN: a new load starts with its first shift this cycle.
        if (bus.cfg_en) begin
          state_d = LOAD;
          cfg_d   = {cfg_q[CFG_W-2:0], bus.cfg_din};
          cnt_d   = CNT_ONE;
          err_d   = 1'b0;
          ff_d    = '0;
        end else if (state_q == RUN && bus.ce) begin
          ff_d = lut;
        end
      end
    endcase
  end

  // State and config registers; reset discards any partial load.
  always_ff @(posedge C or negedge RN) begin
    if (!RN) begin
      state_q <= UNCFG;
      cfg_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      ff_q    <= '0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
    end
  end

  // Datapath outputs are only visible while running.
  assign bus.out      = (state_q == RUN) ? ((byp & lut) | (~byp & ff_q)) : '0;
  assign bus.cout     = (state_q == RUN) & cout_raw;
  assign bus.cfg_dout = cfg_q[CFG_W-1];
  assign bus.cfg_done = (state_q == RUN);
  assign bus.cfg_err  = err_q;
endmodule
